// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM state
// encoding, default geometry and timing, and an index-width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEPTH_DEF       = 256;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int DATA_W_DEF      = 32;

    // Ceiling log2; used for the word-index width and the wait-counter width.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide data array: synchronous write, registered read, one shared index.
// Contents start at zero and are never cleared afterwards, so the array has
// no reset input.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int IDX_W = clog2_f(DEPTH)
)(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port share the index; a read returns the
    // contents before any write on the same edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage data-memory interface.
// Accepts one load/store at a time, waits WAIT_CYCLES, performs the word
// access on dmem_array and holds the response until the pipeline takes it.
// stall freezes the pipeline whenever a request is pending or in flight.
// Optional feature: define DMEM_ERR_EN to flag misaligned or out-of-range
// requests (no store, zero read data, resp_err=1); otherwise addresses wrap.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int DATA_W      = DATA_W_DEF
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int IDX_W = clog2_f(DEPTH);
    // At least one bit so WAIT_CYCLES=0 still yields a legal counter.
    localparam int CNT_W = (clog2_f(WAIT_CYCLES + 1) < 1) ? 1 : clog2_f(WAIT_CYCLES + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               write_q;
    logic               bad_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic               resp_load_q;
    logic               resp_err_q;

    logic               req_bad;
    logic               access;
    logic               arr_we;
    logic               arr_re;
    logic [DATA_W-1:0]  arr_rdata;

`ifdef DMEM_ERR_EN
    // Misaligned, or beyond the last word of the array.
    assign req_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:IDX_W+2] != '0);
`else
    // Byte offset and high bits are dropped: the index wraps modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:IDX_W+2]};
    assign req_bad = 1'b0;
`endif

    // The access happens on the edge that leaves WAIT.
    assign access = (state_q == WAIT) && (cnt_q == '0);
    assign arr_we = access && write_q && !bad_q;
    assign arr_re = access && !write_q && !bad_q;

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clock),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    // Request/response FSM with the wait counter and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            bad_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_load_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        idx_q       <= req_addr[IDX_W+1:2];
                        wdata_q     <= req_wdata;
                        write_q     <= req_write;
                        bad_q       <= req_bad;
                        cnt_q       <= CNT_W'(WAIT_CYCLES);
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_load_q  <= !write_q && !bad_q;
                        resp_err_q   <= bad_q;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_load_q  <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Load data comes straight from the array's read register; stores and
    // errored requests, and every cycle outside RESP, read as zero.
    assign resp_rdata = resp_load_q ? arr_rdata : '0;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign stall      = (req_valid && !req_ready_q) || (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) driven by
// independent directed + random transaction streams, each checked every
// cycle against a transaction-level model with timestamps and a word array.
module tb_dmem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %h expected %h", inst, name, act, exp);
        end
    endtask

    task automatic fail_now(input int inst, input string name);
        checks++;
        errors++;
        $display("FAIL inst%0d %s: timed out waiting", inst, name);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int W = (gi == 0) ? 2 : 0;

        logic        reset = 1'b0;
        logic        req_valid = 1'b0;
        logic        req_write = 1'b0;
        logic [31:0] req_addr = '0;
        logic [31:0] req_wdata = '0;
        logic        resp_ready = 1'b0;
        logic        req_ready, resp_valid, resp_err, stall;
        logic [31:0] resp_rdata;
        bit          chk_en = 1'b0;
        bit          done_i = 1'b0;

        dmem_responder #(
            .DEPTH       (256),
            .WAIT_CYCLES (W),
            .DATA_W      (32)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .req_valid  (req_valid),
            .req_write  (req_write),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .req_ready  (req_ready),
            .resp_valid (resp_valid),
            .resp_ready (resp_ready),
            .resp_rdata (resp_rdata),
            .resp_err   (resp_err),
            .stall      (stall)
        );

        // ---------------- transaction-level model ----------------
        logic [31:0] m_mem [256] = '{default: '0};
        bit          m_busy, m_ready, m_valid, m_err, m_write;
        logic [31:0] m_rdata = '0;
        logic [31:0] m_addr, m_wdata;
        int          m_tacc = 0;
        int          m_cyc = 0;

        function automatic bit is_bad(input logic [31:0] a);
`ifdef DMEM_ERR_EN
            return (a % 4 != 0) || (a >= 32'd1024);
`else
            return (a === 32'hx);
`endif
        endfunction

        always @(posedge clock) begin
            if (!reset) begin
                m_busy = 0; m_ready = 0; m_valid = 0; m_err = 0; m_rdata = '0;
            end else if (m_valid) begin
                if (resp_ready) begin
                    m_valid = 0; m_err = 0; m_rdata = '0; m_busy = 0; m_ready = 1;
                end
            end else if (m_busy) begin
                if (m_cyc == m_tacc + 1 + W) begin
                    int idx;
                    idx = int'((m_addr / 4) % 256);
                    m_err = is_bad(m_addr);
                    if (m_write || m_err) begin
                        m_rdata = '0;
                        if (!m_err) m_mem[idx] = m_wdata;
                    end else begin
                        m_rdata = m_mem[idx];
                    end
                    m_valid = 1;
                end
            end else if (m_ready && req_valid) begin
                m_busy = 1; m_ready = 0; m_tacc = m_cyc;
                m_addr = req_addr; m_wdata = req_wdata; m_write = req_write;
            end else begin
                m_ready = 1;
            end
            m_cyc++;
        end

        // ---------------- per-cycle compare ----------------
        always @(posedge clock) begin
            #1;
            if (chk_en) begin
                chk(gi, "req_ready",  {31'b0, req_ready},  {31'b0, m_ready});
                chk(gi, "resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
                chk(gi, "resp_rdata", resp_rdata, m_rdata);
                chk(gi, "resp_err",   {31'b0, resp_err},   {31'b0, m_err});
                chk(gi, "stall",      {31'b0, stall},
                    {31'b0, (req_valid && !m_ready) || m_busy});
            end
        end

        // ---------------- driver ----------------
        task automatic wait_accept();
            int n;
            n = 0;
            while (!m_busy && n < 50) begin
                @(negedge clock);
                n++;
            end
            if (!m_busy) fail_now(gi, "accept");
        endtask

        task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input int hold, output logic [31:0] got, output int lat,
                           output logic gerr);
            int j;
            @(negedge clock);
            req_valid = 1; req_write = wr; req_addr = addr; req_wdata = data;
            wait_accept();
            j = 0;
            while (resp_valid !== 1'b1 && j < 50) begin
                // Ignored inputs while busy: stray requests and early resp_ready.
                req_valid  = 1'($urandom % 2);
                req_write  = 1'($urandom % 2);
                req_addr   = $urandom;
                req_wdata  = $urandom;
                resp_ready = 1'($urandom % 2);
                @(negedge clock);
                j++;
            end
            if (resp_valid !== 1'b1) fail_now(gi, "resp");
            lat = j; got = resp_rdata; gerr = resp_err;
            resp_ready = 0;
            repeat (hold) begin
                req_valid = 1'($urandom % 2);
                req_addr  = $urandom;
                @(negedge clock);
            end
            resp_ready = 1;
            @(negedge clock);
            resp_ready = 0; req_valid = 0;
            $display("inst%0d W=%0d %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d hold=%0d",
                     gi, W, wr ? "ST" : "LD", addr, data, got, gerr, lat, hold);
        endtask

        initial begin
            logic [31:0] got;
            int          lat;
            logic        ge;

            // Reset held low for three cycles.
            @(negedge clock);
            chk_en = 1;
            chk(gi, "rst_ready", {31'b0, req_ready}, 32'd0);
            repeat (2) @(negedge clock);
            reset = 1;
            @(posedge clock); #1;
            chk(gi, "ready_after_rst", {31'b0, req_ready}, 32'd1);

            // Store then load, second with 5 cycles of backpressure.
            txn(1, 32'h10, 32'hDEADBEEF, 0, got, lat, ge);
            chk(gi, "st_lat", lat, W + 1);
            chk(gi, "st_rdata", got, 32'h0);
            txn(0, 32'h10, 32'h0, 5, got, lat, ge);
            chk(gi, "ld_lat", lat, W + 1);
            chk(gi, "ld_rdata", got, 32'hDEADBEEF);

            // 0x400 aliases word 0 unless error checking is built in.
            txn(1, 32'h400, 32'h55, 1, got, lat, ge);
            txn(0, 32'h0, 32'h0, 0, got, lat, ge);
`ifdef DMEM_ERR_EN
            chk(gi, "wrap_ld", got, 32'h0);
`else
            chk(gi, "wrap_ld", got, 32'h55);
`endif

            // Reset asserted before the access edge: the store must not land.
            @(negedge clock);
            req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'hA5A5;
            wait_accept();
            req_valid = 0;
            repeat ((W > 0) ? W - 1 : 0) @(negedge clock);
            reset = 0;
            @(negedge clock);
            chk(gi, "midrst_valid", {31'b0, resp_valid}, 32'd0);
            @(negedge clock);
            reset = 1;
            @(posedge clock); #1;
            chk(gi, "midrst_ready", {31'b0, req_ready}, 32'd1);
            txn(0, 32'h20, 32'h0, 0, got, lat, ge);
            chk(gi, "midrst_ld", got, 32'h0);

`ifdef DMEM_ERR_EN
            txn(1, 32'h22, 32'h1234, 0, got, lat, ge);
            chk(gi, "err_st_err", {31'b0, ge}, 32'd1);
            txn(0, 32'h20, 32'h0, 0, got, lat, ge);
            chk(gi, "err_st_mem", got, 32'h0);
            chk(gi, "good_ld_err", {31'b0, ge}, 32'd0);
            txn(0, 32'h400, 32'h0, 2, got, lat, ge);
            chk(gi, "oor_ld_err", {31'b0, ge}, 32'd1);
            chk(gi, "oor_ld_rdata", got, 32'h0);
            chk(gi, "oor_lat", lat, W + 1);
            txn(0, 32'h10, 32'h0, 0, got, lat, ge);
            chk(gi, "next_good_err", {31'b0, ge}, 32'd0);
            chk(gi, "next_good_rdata", got, 32'hDEADBEEF);
`endif

            // Random traffic over a small window so loads hit earlier stores.
            for (int t = 0; t < 100; t++) begin
                bit          wr;
                logic [31:0] a;
                wr = 1'($urandom % 2);
                case ($urandom % 8)
                    0:       a = $urandom;
                    1:       a = 32'($urandom_range(0, 63));
                    default: a = 32'($urandom_range(0, 15)) << 2;
                endcase
                txn(wr, a, $urandom, int'($urandom_range(0, 3)), got, lat, ge);
                chk(gi, "rnd_lat", lat, W + 1);
            end
            done_i = 1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_inst[0].done_i && g_inst[1].done_i) && t < 50000) begin
            @(posedge clock);
            t++;
        end
        if (!(g_inst[0].done_i && g_inst[1].done_i)) fail_now(-1, "bench_done");
        @(posedge clock); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM-stage data-memory interface of the pipelined MIPS core.
- The EX/MEM stage issues one load/store request at a time. This block accepts it, inserts a configurable number of wait states, performs the word access on an internal array, and returns a response.
- While a request is in flight it drives a stall indication, which the pipeline uses to freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two, at least 4.
- WAIT_CYCLES, 2: wait states between accept and access; 0 is legal.
- DATA_W, 32: data width; fixed at 32 for this core.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present from EX/MEM.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[IDX_W+1:2], where IDX_W = log2(DEPTH).
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request.
- resp_valid  out  1  response present.
- resp_ready  in  1  pipeline consumes the response.
- resp_rdata  out  32  load data; 0 for stores.
- resp_err  out  1  access error (only meaningful with the optional feature).
- stall  out  1  pipeline freeze request.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, stall=0, wait counter=0.
  - Array contents are not cleared by reset; they are initialised to 0 at time zero only.
- First rising edge after reset=1: req_ready goes to 1.
- All outputs are registered except stall. stall = req_valid & ~req_ready, or (state != IDLE).
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - A request is accepted on an edge where req_valid & req_ready.
  - On accept: latch addr, wdata and write; req_ready goes to 0; counter loads WAIT_CYCLES; state goes to WAIT.
  - Request inputs are ignored when not accepted.
- WAIT:
  - If counter != 0: decrement the counter.
  - If counter == 0: perform the access. A load sets resp_rdata = mem[idx]. A store writes mem[idx] = wdata and sets resp_rdata = 0.
  - At that same edge resp_valid goes to 1 and state goes to RESP.
- Latency: with accept at edge k, resp_valid rises at edge k+1+WAIT_CYCLES. For WAIT_CYCLES=0 this is edge k+1.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready at an edge.
  - On that handshake edge: resp_valid goes to 0, resp_rdata goes to 0, req_ready goes to 1, state goes to IDLE.
- Only one request is outstanding at a time. A new request can be accepted no earlier than the edge after the response handshake.
- resp_ready asserted outside RESP is ignored.
- Address handling: addr[1:0] is ignored. Addresses beyond DEPTH words wrap modulo DEPTH.
- Reset mid-operation:
  - Asserted in WAIT before the access edge: the store is not performed.
  - Asserted in RESP: the store has already been committed; the response is discarded.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - A request is erroneous if addr[1:0] != 0, or if addr >= 4*DEPTH.
  - An erroneous request follows the same timing, but no store is performed and resp_rdata = 0.
  - resp_err = 1 with resp_valid and is cleared with it.
- Undefined: resp_err is tied 0; misaligned and out-of-range addresses wrap as described above.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the default DEPTH and WAIT_CYCLES constants;
  - a log2 helper for IDX_W.
- One natural sub-module: dmem_array, a synchronous-write, registered-read word array with DEPTH/DATA_W parameters. The FSM and counter stay in dmem_responder.

Test Plan:
- Reset and ready: hold reset=0 for 3 cycles, then release → all outputs 0 during reset; req_ready=1 after the first edge following release.
- Store then load at WAIT_CYCLES=2:
  - Store addr 0x10, data 0xDEADBEEF, accepted at edge k → resp_valid at edge k+3 with rdata=0.
  - After the handshake, load 0x10 → rdata 0xDEADBEEF; stall=1 throughout both transactions.
- Response backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid and rdata stay stable and req_ready stays 0; raise resp_ready → IDLE on the next edge.
- Zero wait and wrap at WAIT_CYCLES=0, DEPTH=256:
  - Store 0x55 at 0x400 → aliases word 0, response at edge k+1.
  - Load 0x0 → 0x55.
- Reset mid-WAIT: store 0xA5A5 to 0x20, pull reset low with the counter at 1, release, then load 0x20 → 0 (store not committed).
- With DMEM_ERR_EN defined:
  - Store to 0x22 → resp_err=1 and memory unchanged.
  - Load 0x400 → resp_err=1, rdata=0.
  - Next good load → resp_err=0.
